// File: rtl/fp32_fma_issue_unit_pkg.sv
// Shared FP types for the FMA issue front-end: op encoding, FP32 constants
// and the mapped operand triple fed into the a*b+c datapath.
package fp32_fma_issue_unit_pkg;

  typedef enum logic [2:0] {
    OP_FMADD  = 3'd0,
    OP_FMSUB  = 3'd1,
    OP_FNMSUB = 3'd2,
    OP_FNMADD = 3'd3,
    OP_FMUL   = 3'd4,
    OP_FADD   = 3'd5,
    OP_FSUB   = 3'd6,
    OP_RSVD   = 3'd7
  } fma_op_e;

  localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
  localparam int          FP32_SIGN_BIT = 31;

  typedef struct packed {
    logic [31:0] mullhs;
    logic [31:0] mulrhs;
    logic [31:0] addend;
  } fma_operands_t;

  function automatic logic [31:0] flip_sign(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y[FP32_SIGN_BIT] = ~x[FP32_SIGN_BIT];
    return y;
  endfunction

endpackage

// File: rtl/fp32_fma_result_queue.sv
// Result FIFO behind the non-stallable FMA pipe. Overflow is prevented upstream
// by credits, so push is never refused here; outputs read as zero when empty.
module fp32_fma_result_queue
  import fp32_fma_issue_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int TAG_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [31:0]      push_result,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  input  logic             flush,
  output logic             out_valid,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      result_mem [BUF_DEPTH];
  logic [TAG_W-1:0] tag_mem    [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop_ok;

  assign out_valid  = (count != '0);
  assign pop_ok     = pop && out_valid;
  assign out_result = out_valid ? result_mem[rd_ptr] : '0;
  assign out_tag    = out_valid ? tag_mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop_ok)      count <= count + 1'b1;
      else if (!push && pop_ok) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      result_mem[wr_ptr] <= push_result;
      tag_mem[wr_ptr]    <= push_tag;
    end
  end

endmodule

// File: rtl/fp32_fma_issue_unit.sv
// Issue/retire front-end for the fixed-latency FP32 FMA: maps RISC-V style ops
// onto a*b+c, tracks tags alongside the FMA pipe and buffers results.
module fp32_fma_issue_unit
  import fp32_fma_issue_unit_pkg::*;
#(
  parameter int FMA_LATENCY = 4,
  parameter int BUF_DEPTH   = 4,
  parameter int TAG_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_rs3,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      fma_mullhs,
  output logic [31:0]      fma_mulrhs,
  output logic [31:0]      fma_addend,
  input  logic [31:0]      fma_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int USED_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } issue_stage_t;

  issue_stage_t  stage_q [FMA_LATENCY+1];
  logic [USED_W-1:0] used;
  fma_operands_t mapped;
  fma_operands_t operands_q;
  logic          accept;
  logic          pop;

  function automatic fma_operands_t map_op(input fma_op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
    fma_operands_t m;
    m = '{mullhs: a, mulrhs: b, addend: c};
    case (op)
      OP_FMSUB:  m.addend = flip_sign(c);
      OP_FNMSUB: m.mullhs = flip_sign(a);
      OP_FNMADD: begin
        m.mullhs = flip_sign(a);
        m.addend = flip_sign(c);
      end
      OP_FMUL:   m.addend = FP32_NEG_ZERO;
      OP_FADD:   m = '{mullhs: a, mulrhs: FP32_ONE, addend: b};
      OP_FSUB:   m = '{mullhs: a, mulrhs: FP32_ONE, addend: flip_sign(b)};
      default:   m = '{mullhs: a, mulrhs: b, addend: c};
    endcase
    return m;
  endfunction

  // Both ports are valid/ready: a transfer happens on any edge where valid and
  // ready are both high; a producer holds its payload stable until that edge.
  // Credits count ops from acceptance to pop so the queue can never overflow.
  assign in_ready = !rst && !flush && (used < USED_W'(BUF_DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready && !flush;
  assign mapped   = map_op(fma_op_e'(in_op), in_rs1, in_rs2, in_rs3);

  assign fma_mullhs = operands_q.mullhs;
  assign fma_mulrhs = operands_q.mulrhs;
  assign fma_addend = operands_q.addend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used <= '0;
    end else if (flush) begin
      used <= '0;
    end else if (accept && !pop) begin
      used <= used + 1'b1;
    end else if (!accept && pop) begin
      used <= used - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operands_q <= '0;
    end else if (accept) begin
      operands_q <= mapped;
    end
  end

  // Stage k is valid in the cycle the FMA holds that op's partial result k;
  // the last stage lines up with fma_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= FMA_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: accept, tag: in_tag};
      for (int i = 1; i <= FMA_LATENCY; i++) stage_q[i] <= stage_q[i-1];
      if (flush) begin
        for (int i = 0; i <= FMA_LATENCY; i++) stage_q[i].valid <= 1'b0;
      end
    end
  end

  fp32_fma_result_queue #(
    .BUF_DEPTH (BUF_DEPTH),
    .TAG_W     (TAG_W)
  ) u_result_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (stage_q[FMA_LATENCY].valid),
    .push_result (fma_result),
    .push_tag    (stage_q[FMA_LATENCY].tag),
    .pop         (pop),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_tag     (out_tag)
  );

endmodule
